// File: rtl/riscv_branch_pkg.sv
// Shared branch-compare definitions: funct3 encodings, FSM state type and
// the branch-taken decode used by the sequential comparator.
package riscv_branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } branch_cmp_state_t;

   function automatic logic is_signed_f3(input logic [2:0] f3);
      return (f3[2:1] == 2'b10);
   endfunction

   // Illegal encodings (010, 011) still produce flags but never take the branch.
   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       cmp_lt,
                                         input logic       cmp_eq);
      logic tk;
      tk = 1'b0;
      case (f3)
         F3_BEQ:           tk = cmp_eq;
         F3_BNE:           tk = ~cmp_eq;
         F3_BLT, F3_BLTU:  tk = cmp_lt;
         F3_BGE, F3_BGEU:  tk = ~cmp_lt;
         default:          tk = 1'b0;
      endcase
      return tk;
   endfunction

endpackage

// File: rtl/magcompare_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module magcompare_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   output logic             o_gt,
   output logic             o_lt
);

   assign o_gt = (i_a > i_b);
   assign o_lt = (i_a < i_b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle RISC-V branch comparator: scans operands MSB-first, CHUNK bits
// per cycle, exits at the first unequal chunk and holds the result until accepted.
module branch_compare_seq
   import riscv_branch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       funct3,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             lt,
   output logic             eq,
   output logic             gt,
   output logic             taken
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   branch_cmp_state_t r_state, w_state_next;
   logic [WIDTH-1:0]  r_a, r_b, w_a_next, w_b_next;
   logic [2:0]        r_funct3, w_funct3_next;
   logic [IDX_W-1:0]  r_idx, w_idx_next;
   logic              r_valid, r_lt, r_eq, r_gt, r_taken;
   logic              w_valid_next, w_lt_next, w_eq_next, w_gt_next, w_taken_next;

   logic [CHUNK-1:0]  w_a_chunk [NCHUNK];
   logic [CHUNK-1:0]  w_b_chunk [NCHUNK];
   logic              w_chunk_gt, w_chunk_lt;

   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign w_a_chunk[gi] = r_a[gi*CHUNK +: CHUNK];
      assign w_b_chunk[gi] = r_b[gi*CHUNK +: CHUNK];
   end

   magcompare_chunk #(.CHUNK(CHUNK)) u_cmp (
      .i_a  (w_a_chunk[r_idx]),
      .i_b  (w_b_chunk[r_idx]),
      .o_gt (w_chunk_gt),
      .o_lt (w_chunk_lt)
   );

   assign start_ready  = (r_state == IDLE) & ~reset;
   assign result_valid = r_valid;
   assign lt           = r_lt;
   assign eq           = r_eq;
   assign gt           = r_gt;
   assign taken        = r_taken;

   always_comb begin
      w_state_next  = r_state;
      w_a_next      = r_a;
      w_b_next      = r_b;
      w_funct3_next = r_funct3;
      w_idx_next    = r_idx;
      w_valid_next  = r_valid;
      w_lt_next     = r_lt;
      w_eq_next     = r_eq;
      w_gt_next     = r_gt;
      w_taken_next  = r_taken;
      case (r_state)
         IDLE: begin
            if (start_valid) begin
               // Flipping the sign bit of both operands turns a signed compare into unsigned.
               w_a_next      = is_signed_f3(funct3) ? (a ^ SIGN_MASK) : a;
               w_b_next      = is_signed_f3(funct3) ? (b ^ SIGN_MASK) : b;
               w_funct3_next = funct3;
               w_idx_next    = IDX_W'(NCHUNK - 1);
               w_state_next  = SCAN;
            end
         end
         SCAN: begin
            if (w_chunk_gt) begin
               w_gt_next    = 1'b1;
               w_taken_next = branch_taken(r_funct3, 1'b0, 1'b0);
               w_valid_next = 1'b1;
               w_state_next = DONE;
            end else if (w_chunk_lt) begin
               w_lt_next    = 1'b1;
               w_taken_next = branch_taken(r_funct3, 1'b1, 1'b0);
               w_valid_next = 1'b1;
               w_state_next = DONE;
            end else if (r_idx == '0) begin
               w_eq_next    = 1'b1;
               w_taken_next = branch_taken(r_funct3, 1'b0, 1'b1);
               w_valid_next = 1'b1;
               w_state_next = DONE;
            end else begin
               w_idx_next = r_idx - 1'b1;
            end
         end
         DONE: begin
            if (result_ready) begin
               w_valid_next = 1'b0;
               w_lt_next    = 1'b0;
               w_eq_next    = 1'b0;
               w_gt_next    = 1'b0;
               w_taken_next = 1'b0;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_lt    <= 1'b0;
         r_eq    <= 1'b0;
         r_gt    <= 1'b0;
         r_taken <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_valid_next;
         r_lt    <= w_lt_next;
         r_eq    <= w_eq_next;
         r_gt    <= w_gt_next;
         r_taken <= w_taken_next;
      end
   end

   // Datapath registers need no reset: they are only consumed after a capture.
   always_ff @(posedge clk) begin
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_funct3 <= w_funct3_next;
      r_idx    <= w_idx_next;
   end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Randomized self-checking bench for branch_compare_seq against a behavioural
// model built from signed/unsigned arithmetic compares.
module tb_branch_compare_seq;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 2;
   localparam int NCHUNK = WIDTH / CHUNK;

   logic              clk = 1'b0;
   logic              reset;
   logic              start_valid;
   logic              start_ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic [2:0]        funct3;
   logic              result_valid;
   logic              result_ready;
   logic              lt, eq, gt, taken;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   branch_compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .a            (a),
      .b            (b),
      .funct3       (funct3),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .lt           (lt),
      .eq           (eq),
      .gt           (gt),
      .taken        (taken)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: flags from plain arithmetic compare; latency from the position
   // of the most significant differing bit.
   task automatic model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                        output logic e_lt, output logic e_eq, output logic e_gt,
                        output logic e_tk, output int lat);
      logic [31:0] diff;
      int p;
      e_eq = (x == y);
      if (f3 == 3'b100 || f3 == 3'b101) e_lt = ($signed(x) < $signed(y));
      else                              e_lt = (x < y);
      e_gt = !e_lt && !e_eq;
      case (f3)
         3'b000:         e_tk = e_eq;
         3'b001:         e_tk = !e_eq;
         3'b100, 3'b110: e_tk = e_lt;
         3'b101, 3'b111: e_tk = !e_lt;
         default:        e_tk = 1'b0;
      endcase
      diff = x ^ y;
      if (diff == 0) lat = 1 + NCHUNK;
      else begin
         p = 31;
         while (!diff[p]) p--;
         lat = 1 + NCHUNK - p / CHUNK;
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input string tag);
      logic e_lt, e_eq, e_gt, e_tk;
      int   lat;
      int   n;
      model(f3, x, y, e_lt, e_eq, e_gt, e_tk, lat);
      n = 0;
      while (!start_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_start_ready"}, start_ready, 1);
      start_valid = 1'b1;
      a = x; b = y; funct3 = f3;
      @(posedge clk); #1;
      start_valid = 1'b0;
      a = $urandom; b = $urandom; funct3 = 3'($urandom);
      chk({tag, "_busy"}, start_ready, 0);
      n = 1;
      while (!result_valid && n < NCHUNK + 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!result_valid) begin
         chk({tag, "_timeout"}, 0, 1);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         return;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_flags"}, {lt, eq, gt}, {e_lt, e_eq, e_gt});
      chk({tag, "_taken"}, taken, e_tk);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, result_valid, 1);
         chk({tag, "_hold_out"}, {lt, eq, gt, taken}, {e_lt, e_eq, e_gt, e_tk});
         chk({tag, "_hold_ready"}, start_ready, 0);
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk({tag, "_drop_valid"}, result_valid, 0);
      chk({tag, "_drop_out"}, {lt, eq, gt, taken}, 0);
      chk({tag, "_idle_ready"}, start_ready, 1);
      $display("%s f3=%b a=%h b=%h lt=%0d eq=%0d gt=%0d taken=%0d lat=%0d",
               tag, f3, x, y, e_lt, e_eq, e_gt, e_tk, n);
   endtask

   initial begin
      logic [2:0]  rf3;
      logic [31:0] rx, ry;
      int          mode;

      reset = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
      a = '0; b = '0; funct3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready, 0);
      chk("rst_outputs", {result_valid, lt, eq, gt, taken}, 0);
      reset = 1'b0;
      #1;
      chk("rst_release_ready", start_ready, 1);

      run_op(3'b000, 32'h12345678, 32'h12345678, 0, "beq_equal");
      run_op(3'b100, 32'hFFFFFFFF, 32'h00000001, 0, "blt_neg");
      run_op(3'b110, 32'hFFFFFFFF, 32'h00000001, 0, "bltu_big");
      run_op(3'b101, 32'h00000005, 32'h00000004, 0, "bge_low");
      run_op(3'b001, 32'h00000005, 32'h00000004, 0, "bne_low");
      run_op(3'b111, 32'hA5A5A5A5, 32'hA5A5A5A4, 5, "bgeu_bp");
      run_op(3'b100, 32'h80000000, 32'h7FFFFFFF, 0, "blt_minmax");

      // Abort an equal-operand BEQ mid-scan.
      while (!start_ready) begin @(posedge clk); #1; end
      start_valid = 1'b1; a = 32'hCAFEF00D; b = 32'hCAFEF00D; funct3 = 3'b000;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      chk("abort_ready_in_reset", start_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_outputs", {result_valid, lt, eq, gt, taken}, 0);
      chk("abort_ready", start_ready, 1);
      repeat (20) begin @(posedge clk); #1; end
      chk("abort_no_result", result_valid, 0);
      $display("abort f3=000 a=cafef00d b=cafef00d reset at T+5");

      run_op(3'b010, 32'd3, 32'd1, 0, "illegal_010");

      for (int t = 0; t < 40; t++) begin
         rf3  = 3'($urandom);
         rx   = $urandom;
         mode = $urandom_range(0, 2);
         if (mode == 0)      ry = $urandom;
         else if (mode == 1) ry = rx;
         else                ry = rx ^ (32'h1 << $urandom_range(0, 31));
         run_op(rf3, rx, ry, $urandom_range(0, 3), $sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
